// File: rtl/aura_pe_sched.sv
// Sequencer for one AURA backend PE: streams (query, key/value) index pairs into the PE
// and writes only the final normalized output of each query row to the O buffer.
module aura_pe_sched #(
  parameter int MAX_SEQ_LEN = 64,
  parameter int IDX_W       = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W:0]   num_q,
  input  logic [IDX_W:0]   num_kv,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] q_idx,
  output logic [IDX_W-1:0] kv_idx,
  output logic             pe_inputs_valid,
  output logic             pe_first,
  output logic             pe_last,
  input  logic             pe_backend_ready,
  input  logic             pe_output_valid,
  output logic             pe_ctrl_ready,
  output logic             o_wr_en,
  output logic [IDX_W-1:0] o_wr_idx,
  input  logic             o_wr_ready
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [IDX_W:0]   MAX_N   = (IDX_W + 1)'(MAX_SEQ_LEN);
  localparam logic [IDX_W:0]   LEN_ONE = {{IDX_W{1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W - 1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W:0]   LEN_ZERO = {(IDX_W + 1){1'b0}};

  state_e           state_q, state_d;
  logic [IDX_W-1:0] q_idx_q, q_idx_d;
  logic [IDX_W-1:0] kv_idx_q, kv_idx_d;
  logic [IDX_W-1:0] out_cnt_q, out_cnt_d;
  logic [IDX_W:0]   nq_q, nq_d;
  logic [IDX_W:0]   nkv_q, nkv_d;

  logic in_run_s;
  logic kv_last_s;
  logic q_last_s;
  logic out_final_s;
  logic issue_hs_s;
  logic out_hs_s;
  logic wr_done_s;

  function automatic logic [IDX_W:0] sat_len(input logic [IDX_W:0] n);
    return (n > MAX_N) ? MAX_N : n;
  endfunction

  assign in_run_s    = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign kv_last_s   = ({1'b0, kv_idx_q} == (nkv_q - LEN_ONE));
  assign q_last_s    = ({1'b0, q_idx_q} == (nq_q - LEN_ONE));
  assign out_final_s = ({1'b0, out_cnt_q} == (nkv_q - LEN_ONE));

  assign busy            = in_run_s;
  assign done            = (state_q == S_DONE);
  assign q_idx           = q_idx_q;
  assign kv_idx          = kv_idx_q;
  assign pe_inputs_valid = (state_q == S_ISSUE);
  assign pe_first        = pe_inputs_valid && (kv_idx_q == IDX_ZERO);
  assign pe_last         = pe_inputs_valid && kv_last_s;

  // Partial outputs are dropped freely; the final one waits for the O buffer.
  assign pe_ctrl_ready = in_run_s && (out_final_s ? o_wr_ready : 1'b1);
  assign o_wr_en       = in_run_s && out_final_s && pe_output_valid;
  assign o_wr_idx      = q_idx_q;

  assign issue_hs_s = pe_inputs_valid && pe_backend_ready;
  assign out_hs_s   = pe_output_valid && pe_ctrl_ready;
  assign wr_done_s  = o_wr_en && o_wr_ready;

  // Next-state logic for the run FSM, index counters and latched sizes.
  always_comb begin
    state_d   = state_q;
    q_idx_d   = q_idx_q;
    kv_idx_d  = kv_idx_q;
    out_cnt_d = out_cnt_q;
    nq_d      = nq_q;
    nkv_d     = nkv_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          nq_d      = sat_len(num_q);
          nkv_d     = sat_len(num_kv);
          q_idx_d   = IDX_ZERO;
          kv_idx_d  = IDX_ZERO;
          out_cnt_d = IDX_ZERO;
          if ((num_q == LEN_ZERO) || (num_kv == LEN_ZERO)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE, S_DRAIN: begin
        if (out_hs_s && !out_final_s) begin
          out_cnt_d = out_cnt_q + IDX_ONE;
        end else begin
          out_cnt_d = out_cnt_q;
        end
        // A completed final write wins over a same-cycle last issue: both are taken.
        if (wr_done_s) begin
          out_cnt_d = IDX_ZERO;
          kv_idx_d  = IDX_ZERO;
          if (q_last_s) begin
            state_d = S_DONE;
          end else begin
            q_idx_d = q_idx_q + IDX_ONE;
            state_d = S_ISSUE;
          end
        end else if (issue_hs_s) begin
          if (kv_last_s) begin
            state_d = S_DRAIN;
          end else begin
            kv_idx_d = kv_idx_q + IDX_ONE;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      q_idx_q   <= IDX_ZERO;
      kv_idx_q  <= IDX_ZERO;
      out_cnt_q <= IDX_ZERO;
      nq_q      <= LEN_ZERO;
      nkv_q     <= LEN_ZERO;
    end else begin
      state_q   <= state_d;
      q_idx_q   <= q_idx_d;
      kv_idx_q  <= kv_idx_d;
      out_cnt_q <= out_cnt_d;
      nq_q      <= nq_d;
      nkv_q     <= nkv_d;
    end
  end

endmodule

// File: tb/tb_aura_pe_sched.sv
// Self-checking bench for aura_pe_sched: a queue-based PE model answers issues with
// delayed outputs, and per-run signatures are compared against sequences built from the rules.
module tb_aura_pe_sched;
  localparam int MAXN = 64;
  localparam int IW   = 6;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [IW:0]   num_q, num_kv;
  logic          busy, done;
  logic [IW-1:0] q_idx, kv_idx, o_wr_idx;
  logic          pe_inputs_valid, pe_first, pe_last;
  logic          pe_backend_ready, pe_output_valid, pe_ctrl_ready;
  logic          o_wr_en, o_wr_ready;

  always #5 clk = ~clk;

  aura_pe_sched #(.MAX_SEQ_LEN(MAXN), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_q(num_q), .num_kv(num_kv),
    .busy(busy), .done(done), .q_idx(q_idx), .kv_idx(kv_idx),
    .pe_inputs_valid(pe_inputs_valid), .pe_first(pe_first), .pe_last(pe_last),
    .pe_backend_ready(pe_backend_ready), .pe_output_valid(pe_output_valid),
    .pe_ctrl_ready(pe_ctrl_ready), .o_wr_en(o_wr_en), .o_wr_idx(o_wr_idx),
    .o_wr_ready(o_wr_ready)
  );

  typedef struct { int t; int q; bit last; } pe_ent_t;
  pe_ent_t pq[$];

  int checks = 0, errors = 0, cyc = 0, t_start = 0;
  int p_be, p_wr, lat_min, lat_max, final_block, block_left;
  bit be_pat;
  int iss_cnt, wr_cnt, disc_cnt, done_cnt, done_cyc, last_wr_cyc, first_valid_cyc;
  int valid_cyc, wren_cyc, wblk_cyc, stall_breaks, wr_drops, kind_err, overlap;
  int unsigned iss_sig, wr_sig;
  bit awaiting, prev_stall, prev_wblk, prev_first, prev_last;
  int prev_kv, prev_q;

  function automatic int sat(input int n);
    return (n > MAXN) ? MAXN : n;
  endfunction

  // Expected issue sequence: every (q, kv) pair in order, first on kv 0, last on kv nkv-1.
  function automatic int unsigned exp_iss_sig(input int nq, input int nkv);
    int unsigned s = 0;
    for (int q = 0; q < sat(nq); q++)
      for (int k = 0; k < sat(nkv); k++)
        s = s * 31 + q * 256 + k * 4 + ((k == 0) ? 2 : 0) + ((k == sat(nkv) - 1) ? 1 : 0);
    return s;
  endfunction

  function automatic int unsigned exp_wr_sig(input int nq, input int nkv);
    int unsigned s = 0;
    if (sat(nkv) > 0)
      for (int r = 0; r < sat(nq); r++) s = s * 31 + r + 1;
    return s;
  endfunction

  task automatic clear_logs();
    iss_cnt = 0; wr_cnt = 0; disc_cnt = 0; done_cnt = 0; done_cyc = -1; last_wr_cyc = -1;
    first_valid_cyc = -1; valid_cyc = 0; wren_cyc = 0; wblk_cyc = 0; stall_breaks = 0;
    wr_drops = 0; kind_err = 0; overlap = 0; iss_sig = 0; wr_sig = 0; awaiting = 0;
    prev_stall = 0; prev_wblk = 0; prev_first = 0; prev_last = 0; prev_kv = 0; prev_q = 0;
  endtask

  task automatic set_cfg(input int pbe, input int pwr, input int lmin, input int lmax,
                         input bit bpat, input int fblk);
    p_be = pbe; p_wr = pwr; lat_min = lmin; lat_max = lmax; be_pat = bpat;
    final_block = fblk; block_left = fblk;
  endtask

  // One clock cycle: drive PE/O-buffer inputs, observe handshakes, advance the PE model.
  task automatic tick();
    bit iss, oh, wr;
    pe_ent_t e;
    @(negedge clk);
    if (be_pat) pe_backend_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
    else pe_backend_ready = ($urandom_range(0, 99) < p_be);
    pe_output_valid = (pq.size() > 0) && (pq.size() > 0 ? pq[0].t <= cyc : 1'b0);
    if (pe_output_valid && pq[0].last && block_left > 0) begin
      o_wr_ready = 1'b0; block_left--;
    end else begin
      o_wr_ready = ($urandom_range(0, 99) < p_wr);
    end
    #1;
    iss = pe_inputs_valid && pe_backend_ready;
    oh  = pe_output_valid && pe_ctrl_ready;
    wr  = o_wr_en && o_wr_ready;
    if (prev_stall && !(pe_inputs_valid && int'(kv_idx) == prev_kv && int'(q_idx) == prev_q
                        && pe_first == prev_first && pe_last == prev_last)) stall_breaks++;
    if (prev_wblk && !o_wr_en) wr_drops++;
    if (o_wr_en && !o_wr_ready) wblk_cyc++;
    if (pe_inputs_valid) begin
      valid_cyc++;
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
    end
    if (o_wr_en) wren_cyc++;
    if (iss) begin
      iss_cnt++;
      iss_sig = iss_sig * 31 + int'(q_idx) * 256 + int'(kv_idx) * 4 + int'(pe_first) * 2 + int'(pe_last);
      if (pe_first && awaiting) overlap++;
      if (pe_last) awaiting = 1;
    end
    if (oh) begin
      if (pq[0].last != o_wr_en || (o_wr_en && int'(o_wr_idx) != pq[0].q)) kind_err++;
      if (!o_wr_en) disc_cnt++;
    end
    if (wr) begin
      wr_cnt++; wr_sig = wr_sig * 31 + int'(o_wr_idx) + 1; last_wr_cyc = cyc; awaiting = 0;
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
    prev_stall = pe_inputs_valid && !pe_backend_ready;
    prev_kv = int'(kv_idx); prev_q = int'(q_idx); prev_first = pe_first; prev_last = pe_last;
    prev_wblk = o_wr_en && !o_wr_ready;
    e.t = cyc + int'($urandom_range(lat_min, lat_max)); e.q = int'(q_idx); e.last = pe_last;
    @(posedge clk);
    #1;
    if (rst) begin
      pq.delete(); awaiting = 0;
    end else begin
      if (oh) begin
        if (pq[0].last) block_left = final_block;
        void'(pq.pop_front());
      end
      if (iss) pq.push_back(e);
    end
    cyc++;
  endtask

  task automatic run_job(input int nq, input int nkv, input int ign_at);
    int n = 0;
    clear_logs();
    start = 1'b1; num_q = (IW + 1)'(nq); num_kv = (IW + 1)'(nkv);
    t_start = cyc;
    tick();
    start = 1'b0;
    while (done_cnt == 0 && n < 4000) begin
      if (n == ign_at) begin
        start = 1'b1; num_q = (IW + 1)'(1); num_kv = (IW + 1)'(1);
      end else begin
        start = 1'b0;
      end
      tick();
      n++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    checks++;
    if ({busy, done, pe_inputs_valid, pe_first, pe_last, pe_ctrl_ready, o_wr_en} !== 7'b0) begin
      errors++; $display("FAIL reset_flags got %b want 0000000",
        {busy, done, pe_inputs_valid, pe_first, pe_last, pe_ctrl_ready, o_wr_en});
    end
    checks++;
    if ({q_idx, kv_idx, o_wr_idx} !== 18'd0) begin
      errors++; $display("FAIL reset_idx got %0d/%0d/%0d want 0/0/0", q_idx, kv_idx, o_wr_idx);
    end
    rst = 1'b0; tick();
  endtask

  task automatic test_basic();
    set_cfg(100, 100, 4, 4, 1'b0, 0);
    run_job(2, 3, -1);
    checks++; if (iss_sig !== exp_iss_sig(2, 3)) begin errors++; $display("FAIL basic_issue_seq got %0h want %0h", iss_sig, exp_iss_sig(2, 3)); end
    checks++; if (wr_sig !== exp_wr_sig(2, 3) || wr_cnt != 2) begin errors++; $display("FAIL basic_writes got %0d writes sig %0h want 2 sig %0h", wr_cnt, wr_sig, exp_wr_sig(2, 3)); end
    checks++; if (disc_cnt != 4) begin errors++; $display("FAIL basic_discards got %0d want 4", disc_cnt); end
    checks++; if (done_cnt != 1 || done_cyc != last_wr_cyc + 1) begin errors++; $display("FAIL basic_done got cnt %0d at %0d want 1 at %0d", done_cnt, done_cyc, last_wr_cyc + 1); end
    checks++; if (first_valid_cyc != t_start + 1) begin errors++; $display("FAIL basic_latency got %0d want %0d", first_valid_cyc, t_start + 1); end
    checks++; if (kind_err + overlap != 0 || pq.size() != 0) begin errors++; $display("FAIL basic_ordering got %0d/%0d/%0d want 0/0/0", kind_err, overlap, pq.size()); end
  endtask

  task automatic test_backpressure();
    set_cfg(100, 100, 4, 4, 1'b1, 5);
    run_job(2, 3, -1);
    checks++; if (iss_sig !== exp_iss_sig(2, 3)) begin errors++; $display("FAIL bp_issue_seq got %0h want %0h", iss_sig, exp_iss_sig(2, 3)); end
    checks++; if (stall_breaks != 0) begin errors++; $display("FAIL bp_stall_stable got %0d want 0", stall_breaks); end
    checks++; if (wr_drops != 0 || wblk_cyc != 10) begin errors++; $display("FAIL bp_wr_hold got drops %0d blocked %0d want 0 10", wr_drops, wblk_cyc); end
    checks++; if (wr_cnt != 2 || wr_sig !== exp_wr_sig(2, 3)) begin errors++; $display("FAIL bp_writes got %0d want 2", wr_cnt); end
    checks++; if (done_cnt != 1 || kind_err != 0) begin errors++; $display("FAIL bp_done got %0d kind %0d want 1 0", done_cnt, kind_err); end
  endtask

  task automatic test_single();
    set_cfg(100, 100, 3, 3, 1'b0, 0);
    run_job(1, 1, -1);
    checks++; if (iss_sig !== exp_iss_sig(1, 1) || iss_cnt != 1) begin errors++; $display("FAIL single_issue got %0h cnt %0d want %0h 1", iss_sig, iss_cnt, exp_iss_sig(1, 1)); end
    checks++; if (wr_sig !== exp_wr_sig(1, 1) || disc_cnt != 0) begin errors++; $display("FAIL single_write got %0h disc %0d want %0h 0", wr_sig, disc_cnt, exp_wr_sig(1, 1)); end
    checks++; if (done_cyc != last_wr_cyc + 1) begin errors++; $display("FAIL single_done_lat got %0d want %0d", done_cyc, last_wr_cyc + 1); end
  endtask

  task automatic test_empty();
    int eq[3] = '{0, 3, 0};
    int ek[3] = '{3, 0, 0};
    set_cfg(100, 100, 2, 2, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      run_job(eq[i], ek[i], -1);
      checks++; if (valid_cyc != 0 || wren_cyc != 0) begin errors++; $display("FAIL empty_%0d_activity got valid %0d wr %0d want 0 0", i, valid_cyc, wren_cyc); end
      checks++; if (done_cnt != 1 || done_cyc != t_start + 1) begin errors++; $display("FAIL empty_%0d_done got %0d at %0d want 1 at %0d", i, done_cnt, done_cyc, t_start + 1); end
    end
  endtask

  task automatic test_saturate();
    set_cfg(100, 100, 2, 2, 1'b0, 0);
    run_job(2, 100, -1);
    checks++; if (iss_cnt != 128 || iss_sig !== exp_iss_sig(2, 100)) begin errors++; $display("FAIL sat_kv got %0d want 128", iss_cnt); end
    run_job(100, 1, -1);
    checks++; if (wr_cnt != 64 || wr_sig !== exp_wr_sig(100, 1)) begin errors++; $display("FAIL sat_q got %0d want 64", wr_cnt); end
  endtask

  task automatic test_random();
    int nq, nk;
    for (int j = 0; j < 6; j++) begin
      nq = int'($urandom_range(1, 4)); nk = int'($urandom_range(1, 6));
      set_cfg(int'($urandom_range(30, 100)), int'($urandom_range(30, 100)), 1, 6, 1'b0, 0);
      run_job(nq, nk, -1);
      checks++; if (iss_sig !== exp_iss_sig(nq, nk)) begin errors++; $display("FAIL rand_%0d_issue got %0h want %0h", j, iss_sig, exp_iss_sig(nq, nk)); end
      checks++; if (wr_sig !== exp_wr_sig(nq, nk) || disc_cnt != nq * (nk - 1)) begin errors++; $display("FAIL rand_%0d_out got disc %0d want %0d", j, disc_cnt, nq * (nk - 1)); end
      checks++; if (done_cnt != 1 || stall_breaks + wr_drops + kind_err + overlap != 0) begin errors++; $display("FAIL rand_%0d_proto got done %0d viol %0d want 1 0", j, done_cnt, stall_breaks + wr_drops + kind_err + overlap); end
    end
  endtask

  task automatic test_start_ignored();
    set_cfg(100, 100, 2, 2, 1'b0, 0);
    run_job(2, 2, 3);
    checks++; if (iss_sig !== exp_iss_sig(2, 2) || wr_cnt != 2) begin errors++; $display("FAIL ignore_start got %0d writes want 2", wr_cnt); end
  endtask

  task automatic test_back_to_back();
    set_cfg(100, 100, 2, 2, 1'b0, 0);
    run_job(1, 3, -1);
    checks++; if (first_valid_cyc != t_start + 1 || iss_sig !== exp_iss_sig(1, 3)) begin errors++; $display("FAIL b2b_fresh got first %0d want %0d", first_valid_cyc, t_start + 1); end
  endtask

  task automatic test_reset_midrun();
    int n = 0;
    bit found = 0;
    set_cfg(100, 100, 3, 3, 1'b0, 0);
    clear_logs();
    start = 1'b1; num_q = (IW + 1)'(2); num_kv = (IW + 1)'(4);
    tick();
    start = 1'b0;
    while (!found && n < 200) begin
      if (pe_inputs_valid && q_idx == 6'd1 && kv_idx == 6'd2) found = 1;
      else begin tick(); n++; end
    end
    checks++; if (!found) begin errors++; $display("FAIL midrun_reach got 0 want 1"); end
    rst = 1'b1; tick();
    checks++;
    if ({busy, done, pe_inputs_valid, pe_first, pe_last, pe_ctrl_ready, o_wr_en} !== 7'b0
        || {q_idx, kv_idx, o_wr_idx} !== 18'd0) begin
      errors++; $display("FAIL midrun_reset got busy %b valid %b q %0d kv %0d want 0 0 0 0", busy, pe_inputs_valid, q_idx, kv_idx);
    end
    rst = 1'b0; done_cnt = 0;
    for (int i = 0; i < 10; i++) tick();
    checks++; if (done_cnt != 0 || busy !== 1'b0) begin errors++; $display("FAIL midrun_no_done got %0d want 0", done_cnt); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_q = '0; num_kv = '0;
    pe_backend_ready = 1'b0; pe_output_valid = 1'b0; o_wr_ready = 1'b0;
    set_cfg(100, 100, 4, 4, 1'b0, 0);
    clear_logs();
    test_reset();
    test_basic();
    test_backpressure();
    test_single();
    test_empty();
    test_saturate();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aura_pe_sched.md
Name: aura_pe_sched

Overview:
- Sequencer for one AURA backend PE.
- For each query row it streams key/value indices 0..num_kv-1 into the PE with valid/ready handshakes, and flags the first and last pair of each query.
- It consumes every running partial output and writes only the final normalized output row for each query to the O buffer.
- It sits between the top-level control (start/done) and the PE plus Q/K/V/O buffers. The buffers are indexed combinationally by q_idx/kv_idx/o_wr_idx.

Parameters:
- MAX_SEQ_LEN, 64, maximum number of queries and maximum number of K/V pairs per run.
- IDX_W, 6, index width, equal to $clog2(MAX_SEQ_LEN).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  run request; sampled only in IDLE.
- num_q  in  IDX_W+1  number of query rows; sampled when start is accepted.
- num_kv  in  IDX_W+1  number of K/V pairs per query; sampled when start is accepted.
- busy  out  1  high in ISSUE and DRAIN.
- done  out  1  one-cycle pulse at the end of a run.
- q_idx  out  IDX_W  current query row driven to the Q buffer.
- kv_idx  out  IDX_W  current K/V row driven to the K/V buffers.
- pe_inputs_valid  out  1  the Q/K/V vectors at q_idx/kv_idx are valid for the PE.
- pe_first  out  1  qualifies pe_inputs_valid: first pair of a query, so the PE reinitializes its running max and accumulator.
- pe_last  out  1  qualifies pe_inputs_valid: last pair of a query.
- pe_backend_ready  in  1  PE accepts its inputs.
- pe_output_valid  in  1  PE output vector is valid.
- pe_ctrl_ready  out  1  scheduler consumes the PE output.
- o_wr_en  out  1  write the PE output to O row o_wr_idx.
- o_wr_idx  out  IDX_W  destination O row.
- o_wr_ready  in  1  O buffer accepts the write.

Behaviour:
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- Reset: state=IDLE; every output is 0 (busy, done, q_idx, kv_idx, pe_inputs_valid, pe_first, pe_last, pe_ctrl_ready, o_wr_en, o_wr_idx); all counters and latched sizes are 0.
- Reset mid-run aborts immediately. No done pulse is produced and in-flight PE outputs are abandoned (the PE shares rst).
- IDLE:
  - On start, latch num_q and num_kv, each saturated to MAX_SEQ_LEN.
  - If either latched value is 0, go to DONE. Otherwise go to ISSUE with q_idx=0 and kv_idx=0.
- ISSUE:
  - pe_inputs_valid=1; pe_first=(kv_idx==0); pe_last=(kv_idx==num_kv-1).
  - Issue handshake is pe_inputs_valid && pe_backend_ready. On it, kv_idx increments.
  - On the handshake with pe_last, go to DRAIN; kv_idx holds.
  - While stalled, kv_idx, q_idx, pe_first and pe_last are held stable.
- Output counting:
  - out_cnt counts PE output handshakes for the current query and runs in both ISSUE and DRAIN.
  - For out_cnt != num_kv-1: pe_ctrl_ready=1 and the output is discarded.
  - For the final output: o_wr_en=pe_output_valid, o_wr_idx=q_idx, pe_ctrl_ready=o_wr_ready.
  - Write completes when pe_output_valid && o_wr_ready.
- Write completion:
  - Clear out_cnt and kv_idx.
  - If q_idx==num_q-1, go to DONE. Otherwise increment q_idx and go to ISSUE.
- Queries do not overlap: the next query's first pair is never issued before the previous query's final write completes. This is required by the PE feedback loop.
- If the final output arrives in the same cycle as the last issue handshake, both are taken. The scheduler then goes directly to the next query or to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then go to IDLE.
- start is ignored outside IDLE.
- Minimum latency: start accepted at cycle t → pe_inputs_valid=1 at t+1. The final write → done one cycle later.
- No wrap-around: indices never exceed num-1.

Test Plan:
- num_q=2, num_kv=3, PE always ready with 4-cycle output latency:
  - Issue sequence (q,kv) = (0,0..2), (1,0..2).
  - pe_first only on kv=0; pe_last only on kv=2.
  - Exactly 2 O writes, at rows 0 and 1; 4 partial outputs discarded.
  - done pulses once.
- Backpressure: pe_backend_ready toggles 1,0,0,1, and o_wr_ready=0 for 5 cycles on the final output:
  - kv_idx and pe_first stay stable during stalls.
  - pe_output_valid is held and o_wr_en stays high until accepted.
  - No duplicate O write.
- num_kv=1, num_q=1: single issue with pe_first=pe_last=1; first output is written to O row 0; done asserts one cycle after the write.
- num_q=0 or num_kv=0: no pe_inputs_valid and no o_wr_en; done asserts at t+1.
- num_kv=100 with MAX_SEQ_LEN=64: saturates to 64 issues per query.
- rst asserted mid-ISSUE at q=1, kv=2: next cycle all outputs are 0 and state is IDLE; no done pulse.
- start during busy is ignored; a new start after done begins a fresh run at q=0.
